// File: rtl/maxpool_buffer_ctrl.sv
// Row/window sequencer for the 3x3 stride-2 ping-pong max-pool buffer.
// Loads rows word by word and drains pooled windows after each odd row.
module maxpool_buffer_ctrl #(
    parameter int ROW_WRITES  = 8,
    parameter int OUT_WINDOWS = 15,
    parameter int NUM_ROWS    = 32
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       win_valid,
    input  logic       win_ready,
    output logic [1:0] MPB_In_Sel,
    output logic       MPB_In_Ready,
    output logic       MPB_Out_Ready,
    output logic       busy,
    output logic       frame_done
);

    if ((NUM_ROWS % 2) != 0 || NUM_ROWS < 2 ||
        ROW_WRITES < 1 || OUT_WINDOWS < 1) begin : g_bad_param
        $error("maxpool_buffer_ctrl: illegal parameter set");
    end

    localparam int WW = (ROW_WRITES  > 1) ? $clog2(ROW_WRITES)  : 1;
    localparam int NW = (OUT_WINDOWS > 1) ? $clog2(OUT_WINDOWS) : 1;
    localparam int RW = (NUM_ROWS    > 1) ? $clog2(NUM_ROWS)    : 1;

    localparam logic [WW-1:0] WR_LAST  = WW'(ROW_WRITES - 1);
    localparam logic [NW-1:0] WIN_LAST = NW'(OUT_WINDOWS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(NUM_ROWS - 1);
    localparam logic [WW-1:0] WR_ONE   = WW'(1);
    localparam logic [NW-1:0] WIN_ONE  = NW'(1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    sel_q, sel_d;
    logic [WW-1:0] wr_cnt_q, wr_cnt_d;
    logic [NW-1:0] win_cnt_q, win_cnt_d;
    logic [RW-1:0] row_cnt_q, row_cnt_d;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            sel_q     <= 2'b00;
            wr_cnt_q  <= '0;
            win_cnt_q <= '0;
            row_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            wr_cnt_q  <= wr_cnt_d;
            win_cnt_q <= win_cnt_d;
            row_cnt_q <= row_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        wr_cnt_d   = wr_cnt_q;
        win_cnt_d  = win_cnt_q;
        row_cnt_d  = row_cnt_q;
        in_ready   = 1'b0;
        win_valid  = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = LOAD;
                    sel_d     = 2'b00;
                    wr_cnt_d  = '0;
                    win_cnt_d = '0;
                    row_cnt_d = '0;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (wr_cnt_q == WR_LAST) begin
                        wr_cnt_d = '0;
                        // Odd phase completes a row pair: pool it before loading more
                        if (sel_q[0]) begin
                            state_d = DRAIN;
                        end else begin
                            row_cnt_d = row_cnt_q + ROW_ONE;
                            sel_d     = sel_q + 2'd1;
                        end
                    end else begin
                        wr_cnt_d = wr_cnt_q + WR_ONE;
                    end
                end
            end
            DRAIN: begin
                win_valid = 1'b1;
                if (win_ready) begin
                    if (win_cnt_q == WIN_LAST) begin
                        win_cnt_d = '0;
                        if (row_cnt_q == ROW_LAST) begin
                            state_d = DONE;
                        end else begin
                            row_cnt_d = row_cnt_q + ROW_ONE;
                            sel_d     = sel_q + 2'd1;
                            state_d   = LOAD;
                        end
                    end else begin
                        win_cnt_d = win_cnt_q + WIN_ONE;
                    end
                end
            end
            DONE: begin
                frame_done = 1'b1;
                sel_d      = 2'b00;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign MPB_In_Sel    = sel_q;
    assign MPB_In_Ready  = in_valid & in_ready;
    assign MPB_Out_Ready = win_valid & win_ready;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_maxpool_buffer_ctrl.sv
// Directed bench for maxpool_buffer_ctrl: a 4-row instance for the
// timing scenarios and a default-size instance for a stalled full frame.
module tb_maxpool_buffer_ctrl;

    logic       CLK;
    logic       RST_N;
    logic       start, in_valid, win_ready;
    logic       in_ready, win_valid;
    logic [1:0] MPB_In_Sel;
    logic       MPB_In_Ready, MPB_Out_Ready, busy, frame_done;

    logic       start2, in_valid2, win_ready2;
    logic       in_ready2, win_valid2;
    logic [1:0] sel2;
    logic       inr2, outr2, busy2, done2;

    maxpool_buffer_ctrl #(
        .ROW_WRITES (8),
        .OUT_WINDOWS(15),
        .NUM_ROWS   (4)
    ) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .start        (start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .win_valid    (win_valid),
        .win_ready    (win_ready),
        .MPB_In_Sel   (MPB_In_Sel),
        .MPB_In_Ready (MPB_In_Ready),
        .MPB_Out_Ready(MPB_Out_Ready),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    maxpool_buffer_ctrl dut_full (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .start        (start2),
        .in_valid     (in_valid2),
        .in_ready     (in_ready2),
        .win_valid    (win_valid2),
        .win_ready    (win_ready2),
        .MPB_In_Sel   (sel2),
        .MPB_In_Ready (inr2),
        .MPB_Out_Ready(outr2),
        .busy         (busy2),
        .frame_done   (done2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    // Strobe bookkeeping for the small instance, sampled mid-cycle
    int m_wr = 0, m_sh = 0, m_done = 0, m_dcyc = 0;
    int m_excl = 0, m_stall = 0, m_rise = 0;
    int wsel[4] = '{0, 0, 0, 0};
    int ssel[4] = '{0, 0, 0, 0};
    logic prev_busy = 1'b0;

    always @(negedge CLK) begin
        if (MPB_In_Ready) begin
            m_wr++;
            wsel[MPB_In_Sel]++;
        end
        if (MPB_Out_Ready) begin
            m_sh++;
            ssel[MPB_In_Sel]++;
        end
        if (MPB_In_Ready && MPB_Out_Ready) m_excl++;
        if (win_valid && !win_ready) m_stall++;
        if (frame_done) begin
            m_done++;
            m_dcyc = cyc;
        end
        if (in_ready && !prev_busy) m_rise = cyc;
        prev_busy = busy;
    end

    int f_wr = 0, f_sh = 0, f_done = 0, f_excl = 0;
    always @(negedge CLK) begin
        if (inr2) f_wr++;
        if (outr2) f_sh++;
        if (inr2 && outr2) f_excl++;
        if (done2) f_done++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int outs();
        return int'({in_ready, win_valid, MPB_In_Sel, MPB_In_Ready,
                     MPB_Out_Ready, busy, frame_done});
    endfunction

    int s_cyc;
    int b_wr, b_sh, b_done, b_stall;
    int bw[4];
    int bs[4];

    // mode 0 plain, 1 in_valid toggles, 2 drain stall, 3 stray starts, 4 reset
    task automatic run_frame(input int mode, output int dur);
        b_wr    = m_wr;
        b_sh    = m_sh;
        b_done  = m_done;
        b_stall = m_stall;
        bw      = wsel;
        bs      = ssel;
        dur     = -1;
        @(posedge CLK);
        #1;
        start     = 1'b1;
        in_valid  = 1'b1;
        win_ready = 1'b1;
        s_cyc     = cyc;
        for (int k = 1; k <= 400; k++) begin
            @(posedge CLK);
            #1;
            start     = (mode == 3) && (k == 5 || k == 20);
            in_valid  = (mode == 1) ? !k[0] : 1'b1;
            win_ready = !((mode == 2) && k >= 22 && k <= 26);
            if (mode == 4 && k == 22) begin
                RST_N = 1'b0;
                #1;
                chk("async_rst_outs", outs(), 0);
                dur = -2;
                break;
            end
            if (m_done != b_done) begin
                dur = m_dcyc - s_cyc;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic chk_frame(input string tag, input int dur, input int exp);
        chk({tag, "_done_cyc"}, dur, exp);
        chk({tag, "_writes"}, m_wr - b_wr, 32);
        chk({tag, "_shifts"}, m_sh - b_sh, 30);
        chk({tag, "_nframes"}, m_done - b_done, 1);
        chk({tag, "_w_sel00"}, wsel[0] - bw[0], 8);
        chk({tag, "_w_sel11"}, wsel[3] - bw[3], 8);
        chk({tag, "_s_sel01"}, ssel[1] - bs[1], 15);
        chk({tag, "_s_sel11"}, ssel[3] - bs[3], 15);
        chk({tag, "_s_even"}, (ssel[0] - bs[0]) + (ssel[2] - bs[2]), 0);
    endtask

    int d;

    initial begin
        RST_N      = 1'b0;
        start      = 1'b0;
        in_valid   = 1'b0;
        win_ready  = 1'b0;
        start2     = 1'b0;
        in_valid2  = 1'b0;
        win_ready2 = 1'b0;
        #3;
        chk("reset_outs", outs(), 0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("idle_outs", outs(), 0);

        run_frame(0, d);
        chk_frame("s1", d, 63);
        chk("s1_in_ready_latency", m_rise - s_cyc, 1);
        chk("s1_w_sel01", wsel[1] - bw[1], 8);
        chk("s1_w_sel10", wsel[2] - bw[2], 8);
        @(negedge CLK);
        chk("s1_idle_after", outs(), 0);

        run_frame(1, d);
        chk_frame("s2", d, 94);

        run_frame(2, d);
        chk_frame("s3", d, 68);
        chk("s3_stall_cycles", m_stall - b_stall, 5);

        run_frame(3, d);
        chk_frame("s4", d, 63);

        run_frame(4, d);
        chk("s5_windows_before_rst", m_sh - b_sh, 5);
        chk("s5_sel_in_rst", int'(MPB_In_Sel), 0);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (3) @(negedge CLK);
        chk("s5_no_frame_done", m_done - b_done, 0);
        chk("s5_idle_outs", outs(), 0);
        run_frame(0, d);
        chk_frame("s5_rerun", d, 63);

        chk("excl_small", m_excl, 0);

        @(posedge CLK);
        #1;
        start2     = 1'b1;
        in_valid2  = 1'b1;
        win_ready2 = 1'b1;
        for (int k = 0; k < 4000 && f_done == 0; k++) begin
            @(posedge CLK);
            #1;
            start2     = 1'b0;
            in_valid2  = ($urandom_range(0, 3) != 0);
            win_ready2 = ($urandom_range(0, 3) != 0);
        end
        repeat (3) @(posedge CLK);
        chk("s6_writes", f_wr, 256);
        chk("s6_shifts", f_sh, 240);
        chk("s6_nframes", f_done, 1);
        chk("s6_excl", f_excl, 0);
        chk("s6_idle", int'({busy2, sel2}), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
